// File: rtl/alu_issue_pkg.sv
// Operation encoding shared by the ALU issue logic and the ALU itself.
package alu_issue_pkg;

  typedef enum logic [2:0] {
    ALU_OP_NONE = 3'd0,
    ALU_OP_ADD  = 3'd1,
    ALU_OP_SUB  = 3'd2,
    ALU_OP_AND  = 3'd3,
    ALU_OP_OR   = 3'd4,
    ALU_OP_XOR  = 3'd5
  } alu_operation_e;

endpackage

// File: rtl/alu_issue.sv
// ALU execute/busy initiator: queues requests, issues them one at a time to the ALU,
// waits for busy to drop (with a watchdog) and returns results on a backpressured port.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               ce,
  input  logic               reset,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  alu_operation_e     req_op,
  input  logic [15:0]        req_ta,
  input  logic [15:0]        req_tb,
  input  logic [TAG_W-1:0]   req_tag,
  output alu_operation_e     alu_operation,
  output logic [15:0]        alu_ta,
  output logic [15:0]        alu_tb,
  output logic               alu_execute,
  input  logic               alu_busy,
  input  logic [15:0]        alu_result,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [15:0]        wb_data,
  output logic [TAG_W-1:0]   wb_tag,
  output logic               wb_error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  alu_operation_e   q_op_r  [DEPTH];
  logic [15:0]      q_ta_r  [DEPTH];
  logic [15:0]      q_tb_r  [DEPTH];
  logic [TAG_W-1:0] q_tag_r [DEPTH];

  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  state_e           state_r;
  logic [WW-1:0]    wdog_r;
  logic [TAG_W-1:0] cur_tag_r;

  logic             push_s;
  logic             pop_s;
  logic             empty_s;
  logic             launch_s;

  // Handshake qualifiers and post-update FIFO occupancy.
  always_comb begin
    empty_s  = (count_r == {CW{1'b0}});
    push_s   = ce & req_valid & req_ready & ~flush;
    launch_s = (state_r == IDLE) | ((state_r == DONE) & wb_ready);
    pop_s    = ce & ~flush & ~empty_s & launch_s;
    if (ce & flush) begin
      count_next_s = {CW{1'b0}};
    end else begin
      count_next_s = count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
    end
  end

  // Request storage; contents are only meaningful below count_r so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_op_r[wr_ptr_r]  <= req_op;
      q_ta_r[wr_ptr_r]  <= req_ta;
      q_tb_r[wr_ptr_r]  <= req_tb;
      q_tag_r[wr_ptr_r] <= req_tag;
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      count_r   <= {CW{1'b0}};
      req_ready <= 1'b1;
    end else if (ce) begin
      if (flush) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r   <= count_next_s;
      req_ready <= (count_next_s != FULL_CNT);
    end
  end

  // Issue/wait/writeback sequencer with all ALU and writeback outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      alu_execute   <= 1'b0;
      alu_operation <= ALU_OP_NONE;
      alu_ta        <= 16'h0000;
      alu_tb        <= 16'h0000;
      cur_tag_r     <= {TAG_W{1'b0}};
      wdog_r        <= {WW{1'b0}};
      wb_valid      <= 1'b0;
      wb_data       <= 16'h0000;
      wb_tag        <= {TAG_W{1'b0}};
      wb_error      <= 1'b0;
    end else if (ce) begin
      if (flush) begin
        // An op already handed to the ALU finishes there, but its result is dropped.
        state_r     <= IDLE;
        alu_execute <= 1'b0;
        wb_valid    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (pop_s) begin
              alu_operation <= q_op_r[rd_ptr_r];
              alu_ta        <= q_ta_r[rd_ptr_r];
              alu_tb        <= q_tb_r[rd_ptr_r];
              cur_tag_r     <= q_tag_r[rd_ptr_r];
              alu_execute   <= 1'b1;
              state_r       <= ISSUE;
            end
          end
          ISSUE: begin
            alu_execute <= 1'b0;
            wdog_r      <= {WW{1'b0}};
            state_r     <= WAIT;
          end
          WAIT: begin
            if (!alu_busy) begin
              wb_data  <= alu_result;
              wb_tag   <= cur_tag_r;
              wb_error <= 1'b0;
              wb_valid <= 1'b1;
              state_r  <= DONE;
            end else if (wdog_r == WD_LAST) begin
              wb_data  <= 16'h0000;
              wb_tag   <= cur_tag_r;
              wb_error <= 1'b1;
              wb_valid <= 1'b1;
              state_r  <= DONE;
            end else begin
              wdog_r <= wdog_r + WW'(1);
            end
          end
          DONE: begin
            if (wb_ready) begin
              wb_valid <= 1'b0;
              // Back-to-back issue straight from DONE avoids an idle bubble.
              if (pop_s) begin
                alu_operation <= q_op_r[rd_ptr_r];
                alu_ta        <= q_ta_r[rd_ptr_r];
                alu_tb        <= q_tb_r[rd_ptr_r];
                cur_tag_r     <= q_tag_r[rd_ptr_r];
                alu_execute   <= 1'b1;
                state_r       <= ISSUE;
              end else begin
                state_r <= IDLE;
              end
            end
          end
          default: begin
            alu_execute <= 1'b0;
            state_r     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Randomized bench for alu_issue: a behavioural ALU plus a transaction scoreboard
// predict every issue and every writeback.
module tb_alu_issue;
  import alu_issue_pkg::*;

  localparam int DEPTH   = 2;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 16;

  logic             clk;
  logic             ce;
  logic             reset;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  alu_operation_e   req_op;
  logic [15:0]      req_ta;
  logic [15:0]      req_tb;
  logic [TAG_W-1:0] req_tag;
  alu_operation_e   alu_operation;
  logic [15:0]      alu_ta;
  logic [15:0]      alu_tb;
  logic             alu_execute;
  logic             alu_busy;
  logic [15:0]      alu_result;
  logic             wb_valid;
  logic             wb_ready;
  logic [15:0]      wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_error;

  alu_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .ce(ce), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_ta(req_ta), .req_tb(req_tb), .req_tag(req_tag),
    .alu_operation(alu_operation), .alu_ta(alu_ta), .alu_tb(alu_tb),
    .alu_execute(alu_execute), .alu_busy(alu_busy), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_tag(wb_tag), .wb_error(wb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    alu_operation_e   op;
    logic [15:0]      ta;
    logic [15:0]      tb;
    logic [TAG_W-1:0] tag;
    int               lat;
  } req_t;

  typedef struct {
    logic [15:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } wb_t;

  req_t        iss_q[$];
  wb_t         wb_q[$];
  int          req_lat;
  int          busy_left;
  int          n_exec;
  int          n_checks;
  int          n_errors;
  logic [15:0] res_m;
  bit          hold_p;
  logic [31:0] hold_v;

  function automatic logic [15:0] ref_alu(alu_operation_e op, logic [15:0] a, logic [15:0] b);
    case (op)
      ALU_OP_ADD: return a + b;
      ALU_OP_SUB: return a - b;
      ALU_OP_AND: return a & b;
      ALU_OP_OR:  return a | b;
      ALU_OP_XOR: return a ^ b;
      default:    return 16'hBEEF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge; inputs are already set.
  task automatic step();
    req_t r;
    wb_t  w;
    if (hold_p)
      chk("wb_hold", {10'd0, wb_valid, wb_error, wb_tag, wb_data}, hold_v);
    alu_busy   = (busy_left > 0);
    alu_result = res_m;
    if (ce) begin
      if (alu_execute) begin
        n_exec++;
        if (iss_q.size() == 0) begin
          chk("exec_spurious", 32'd1, 32'd0);
        end else begin
          r = iss_q.pop_front();
          chk("exec_op", 32'(alu_operation), 32'(r.op));
          chk("exec_ta", 32'(alu_ta), 32'(r.ta));
          chk("exec_tb", 32'(alu_tb), 32'(r.tb));
          busy_left = r.lat;
          res_m     = ref_alu(r.op, r.ta, r.tb);
        end
      end else if (busy_left > 0) begin
        busy_left--;
      end
      if (wb_valid && wb_ready && !flush) begin
        if (wb_q.size() == 0) begin
          chk("wb_spurious", 32'd1, 32'd0);
        end else begin
          w = wb_q.pop_front();
          chk("wb_data", 32'(wb_data), 32'(w.data));
          chk("wb_tag", 32'(wb_tag), 32'(w.tag));
          chk("wb_error", 32'(wb_error), 32'(w.err));
        end
      end
      if (req_valid && req_ready && !flush) begin
        r.op = req_op; r.ta = req_ta; r.tb = req_tb; r.tag = req_tag; r.lat = req_lat;
        iss_q.push_back(r);
        w.err  = (req_lat >= TIMEOUT);
        w.data = w.err ? 16'h0000 : ref_alu(req_op, req_ta, req_tb);
        w.tag  = req_tag;
        wb_q.push_back(w);
      end
      if (flush) begin
        iss_q.delete();
        wb_q.delete();
      end
    end
    hold_p = wb_valid && !(ce && (wb_ready || flush));
    hold_v = {10'd0, wb_valid, wb_error, wb_tag, wb_data};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_req(input alu_operation_e op, input logic [15:0] a, input logic [15:0] b,
                          input logic [TAG_W-1:0] tag, input int lat);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    req_valid = 1'b1; req_op = op; req_ta = a; req_tb = b; req_tag = tag; req_lat = lat;
    while (!done && n < 50) begin
      done = req_ready && ce;
      step();
      n++;
    end
    req_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int k;
    int e0;
    int cnt;
    int lat_tab[6];
    lat_tab = '{0, 0, 1, 3, TIMEOUT - 1, TIMEOUT};
    n_checks = 0; n_errors = 0; n_exec = 0; busy_left = 0; res_m = 16'h0000;
    hold_p = 1'b0; hold_v = 32'd0; req_lat = 0;
    ce = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = ALU_OP_NONE;
    req_ta = 16'h0000; req_tb = 16'h0000; req_tag = '0; wb_ready = 1'b1;
    alu_busy = 1'b0; alu_result = 16'h0000;
    reset = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_execute", 32'(alu_execute), 32'd0);
    chk("rst_operation", 32'(alu_operation), 32'(ALU_OP_NONE));
    chk("rst_ta_tb", {alu_ta, alu_tb}, 32'd0);
    chk("rst_wb", {10'd0, wb_valid, wb_error, wb_tag, wb_data}, 32'd0);
    reset = 1'b0;

    // 1: single ADD, latency and one execute pulse
    wb_ready = 1'b0;
    e0 = n_exec;
    push_req(ALU_OP_ADD, 16'h1234, 16'h0101, 4'd3, 0);
    k = 1;
    while (!wb_valid && k < 20) begin step(); k++; end
    chk("t1_latency", 32'(k), 32'd4);
    chk("t1_data", 32'(wb_data), 32'h1335);
    chk("t1_tag", 32'(wb_tag), 32'd3);
    chk("t1_error", 32'(wb_error), 32'd0);
    chk("t1_exec_count", 32'(n_exec - e0), 32'd1);
    wb_ready = 1'b1;
    step(); step();

    // 2: fill while writeback is stalled, then drain in order
    wb_ready = 1'b0;
    push_req(ALU_OP_ADD, 16'h0001, 16'h0002, 4'd1, 0);
    push_req(ALU_OP_ADD, 16'h0010, 16'h0020, 4'd2, 0);
    push_req(ALU_OP_ADD, 16'h0100, 16'h0200, 4'd3, 0);
    step(); step(); step();
    chk("t2_full", 32'(req_ready), 32'd0);
    chk("t2_wb_valid", 32'(wb_valid), 32'd1);
    chk("t2_wb_tag", 32'(wb_tag), 32'd1);
    wb_ready = 1'b1;
    cnt = 0;
    while ((wb_q.size() != 0 || wb_valid) && cnt < 40) begin step(); cnt++; end
    chk("t2_drain", 32'(wb_q.size()), 32'd0);
    chk("t2_ready", 32'(req_ready), 32'd1);

    // 3: ALU never clears busy -> watchdog abort
    wb_ready = 1'b0;
    push_req(ALU_OP_XOR, 16'hAAAA, 16'h5555, 4'd9, 1000);
    k = 1;
    while (!wb_valid && k < 60) begin step(); k++; end
    chk("t3_latency", 32'(k), 32'(TIMEOUT + 3));
    chk("t3_error", 32'(wb_error), 32'd1);
    chk("t3_data", 32'(wb_data), 32'd0);
    wb_ready = 1'b1;
    step(); step();

    // 4: ce toggling every cycle, wrap-around ADD
    wb_ready = 1'b0;
    e0 = n_exec;
    push_req(ALU_OP_ADD, 16'hFFFF, 16'h0001, 4'd4, 0);
    k = 1;
    while (!wb_valid && k < 40) begin ce = (k % 2 == 0); step(); k++; end
    ce = 1'b1;
    chk("t4_latency", 32'(k), 32'd7);
    chk("t4_data", 32'(wb_data), 32'd0);
    chk("t4_exec_count", 32'(n_exec - e0), 32'd1);
    wb_ready = 1'b1;
    step(); step();

    // 5: flush while waiting with one request queued
    e0 = n_exec;
    push_req(ALU_OP_SUB, 16'h0100, 16'h0001, 4'd4, 6);
    push_req(ALU_OP_OR, 16'h0F00, 16'h00F0, 4'd5, 0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    cnt = 0;
    repeat (25) begin
      if (wb_valid) cnt++;
      step();
    end
    chk("t5_no_wb", 32'(cnt), 32'd0);
    chk("t5_ready", 32'(req_ready), 32'd1);
    chk("t5_exec_count", 32'(n_exec - e0), 32'd1);

    // 6: asynchronous reset while waiting
    push_req(ALU_OP_AND, 16'hF0F0, 16'hFF00, 4'd6, 10);
    push_req(ALU_OP_ADD, 16'h0002, 16'h0003, 4'd7, 0);
    push_req(ALU_OP_ADD, 16'h0004, 16'h0005, 4'd8, 0);
    chk("t6_pre_ready", 32'(req_ready), 32'd0);
    chk("t6_pre_op", 32'(alu_operation), 32'(ALU_OP_AND));
    #2 reset = 1'b1;
    #1;
    chk("t6_execute", 32'(alu_execute), 32'd0);
    chk("t6_wb_valid", 32'(wb_valid), 32'd0);
    chk("t6_ready", 32'(req_ready), 32'd1);
    chk("t6_operation", 32'(alu_operation), 32'(ALU_OP_NONE));
    chk("t6_ta", 32'(alu_ta), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    iss_q.delete(); wb_q.delete(); busy_left = 0; hold_p = 1'b0;
    push_req(ALU_OP_SUB, 16'h0005, 16'h0007, 4'd2, 0);
    cnt = 0;
    while ((wb_q.size() != 0 || wb_valid) && cnt < 20) begin step(); cnt++; end
    chk("t6_recover", 32'(wb_q.size()), 32'd0);

    // Random traffic against the scoreboard
    for (int i = 0; i < 600; i++) begin
      ce        = ($urandom_range(0, 3) != 0);
      wb_ready  = ($urandom_range(0, 2) != 0);
      req_valid = ($urandom_range(0, 1) != 0);
      req_op    = alu_operation_e'($urandom_range(0, 5));
      req_ta    = 16'($urandom);
      req_tb    = 16'($urandom);
      req_tag   = TAG_W'($urandom);
      req_lat   = lat_tab[$urandom_range(0, 5)];
      step();
    end
    ce = 1'b1; req_valid = 1'b0; wb_ready = 1'b1;
    cnt = 0;
    while ((wb_q.size() != 0 || iss_q.size() != 0 || wb_valid) && cnt < 400) begin
      step();
      cnt++;
    end
    chk("final_wb_empty", 32'(wb_q.size()), 32'd0);
    chk("final_iss_empty", 32'(iss_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
